// File: rtl/burst_mod_pkg.sv
// burst_mod_pkg: shared state encoding, mode constants and width helper for burst_modulator
package burst_mod_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic MODE_OOK = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/burst_modulator_window_timer.sv
// window_timer: packet tick counter and look-ahead window/subcarrier strobes for the next edge
module window_timer import burst_mod_pkg::*; #(
  parameter int CNT_W      = 16,
  parameter int NUM_SYM    = 8,
  parameter int WIN_START  = 720,
  parameter int WIN_LEN    = 80,
  parameter int SYM_PERIOD = 160,
  parameter int HALF_PER   = 4,
  parameter int TRIM_W     = 6
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic [TRIM_W-1:0] trim,
  output logic              win,
  output logic              sub,
  output logic              close,
  output logic              last
);
  localparam int PW = cnt_w(SYM_PERIOD);
  localparam int IW = cnt_w(NUM_SYM + 1);
  localparam int HW = cnt_w(HALF_PER);
  logic [CNT_W-1:0] cnt, cnt_n, s_reg, s_val;
  logic [CNT_W:0]   s_sum;
  logic             started, started_n, wrap, hp_top, sub_r, sub_n;
  logic [PW-1:0]    ph, ph_n;
  logic [IW-1:0]    idx, idx_n;
  logic [HW-1:0]    hp, hp_n;
  always_comb begin
    s_sum = {1'b0, CNT_W'(WIN_START)} + {{(CNT_W + 1 - TRIM_W){trim[TRIM_W-1]}}, trim};
    s_val = (s_sum[CNT_W] || s_sum == '0) ? CNT_W'(1) : s_sum[CNT_W-1:0];
    cnt_n = &cnt ? cnt : cnt + 1'b1;
    started_n = started || cnt_n == s_reg;
    wrap = ph == PW'(SYM_PERIOD - 1);
    ph_n = (!started || wrap) ? '0 : ph + 1'b1;
    idx_n = (started && wrap) ? idx + 1'b1 : idx;
    hp_top = hp == HW'(HALF_PER - 1);
    hp_n = (ph_n == '0 || hp_top) ? '0 : hp + 1'b1;
    sub_n = (ph_n == '0) ? 1'b1 : sub_r ^ hp_top;
    win = started_n && ph_n < PW'(WIN_LEN) && idx_n < IW'(NUM_SYM);
    close = started_n && ph_n == PW'(WIN_LEN);
    last = close && idx_n == IW'(NUM_SYM - 1);
    sub = sub_n;
  end
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      s_reg   <= '0;
      started <= 1'b0;
      ph      <= '0;
      idx     <= '0;
      hp      <= '0;
      sub_r   <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      s_reg   <= s_val;
      started <= 1'b0;
      ph      <= '0;
      idx     <= '0;
      hp      <= '0;
      sub_r   <= 1'b0;
    end else if (run) begin
      cnt     <= cnt_n;
      started <= started_n;
      ph      <= ph_n;
      idx     <= idx_n;
      hp      <= hp_n;
      sub_r   <= sub_n;
    end
  end
endmodule

// File: rtl/burst_modulator.sv
// burst_modulator: envelope-triggered multi-window OOK/subcarrier analog-switch modulator
module burst_modulator import burst_mod_pkg::*; #(
  parameter int CNT_W      = 16,
  parameter int NUM_SYM    = 8,
  parameter int WIN_START  = 720,
  parameter int WIN_LEN    = 80,
  parameter int SYM_PERIOD = 160,
  parameter int HALF_PER   = 4,
  parameter int TRIM_W     = 6
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               EN,
  input  logic               DEC_IN,
  input  logic               mode_in,
  input  logic [TRIM_W-1:0]  trim_in,
  input  logic [NUM_SYM-1:0] pl_data,
  input  logic               pl_valid,
  output logic               pl_ready,
  output logic               ASW_OUT,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic               underrun
);
  state_t             state, state_n;
  logic               full, mode_r;
  logic [NUM_SYM-1:0] pl_buf, sh;
  logic               start, run, take, asw_n, done_n, abort_n, und_n;
  logic               win, sub, close, last;
  window_timer #(
    .CNT_W(CNT_W), .NUM_SYM(NUM_SYM), .WIN_START(WIN_START), .WIN_LEN(WIN_LEN),
    .SYM_PERIOD(SYM_PERIOD), .HALF_PER(HALF_PER), .TRIM_W(TRIM_W)
  ) u_timer (
    .CLK(CLK), .rst_n(rst_n), .start(start), .run(run), .trim(trim_in),
    .win(win), .sub(sub), .close(close), .last(last)
  );
  assign pl_ready = !full;
  assign busy = state == RUN;
  always_comb begin
    state_n = state;
    start = 1'b0;
    run = 1'b0;
    take = 1'b0;
    asw_n = 1'b0;
    done_n = 1'b0;
    abort_n = 1'b0;
    und_n = 1'b0;
    case (state)
      IDLE: if (EN && DEC_IN) begin
        start = 1'b1;
        take = full;
        und_n = !full;
        state_n = full ? RUN : HOLD;
      end
      RUN: if (!EN || !DEC_IN) begin
        abort_n = 1'b1;
        state_n = IDLE;
      end else begin
        run = 1'b1;
        done_n = last;
        state_n = last ? HOLD : RUN;
        asw_n = win && sh[0] && (mode_r != MODE_SUB || sub);
      end
      HOLD: state_n = (!EN || !DEC_IN) ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      full     <= 1'b0;
      pl_buf   <= '0;
      sh       <= '0;
      mode_r   <= MODE_OOK;
      ASW_OUT  <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      ASW_OUT  <= asw_n;
      done     <= done_n;
      abort    <= abort_n;
      underrun <= und_n;
      full     <= take ? 1'b0 : full | pl_valid;
      pl_buf   <= (pl_valid && !full) ? pl_data : pl_buf;
      mode_r   <= start ? mode_in : mode_r;
      sh       <= start ? pl_buf : (run && close) ? sh >> 1 : sh;
    end
  end
endmodule
